// File: rtl/line_rasterizer.sv
// line_rasterizer
//   Bresenham line generator. A line request (x0,y0)->(x1,y1) is captured on
//   start, then every pixel of the line is emitted in order on a valid/ready
//   pixel stream, followed by a one-cycle done pulse.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               draw request, only looked at in IDLE
//   x0, y0, x1, y1      line endpoints
//   color_in            colour for every pixel of the line
//   x, y, color         current pixel
//   pixel_valid         x/y/color hold a pixel to write
//   pixel_ready         consumer accepts the pixel
//   busy                line in progress (INIT, DRAW, FINISH)
//   done                one-cycle pulse after the last pixel
//   dbg_state_o         current FSM state (IDLE=0, INIT=1, DRAW=2, FINISH=3)
//
// Handshake: a pixel transfers on a rising edge where pixel_valid and
// pixel_ready are both high. Once pixel_valid is raised, x/y/color stay
// stable and pixel_valid stays high until that transfer happens.
//
// Optional build macro LINE_RASTERIZER_CLIP_EN: pixels outside
// SCREEN_W x SCREEN_H are not presented (pixel_valid low) and are stepped
// over at one per cycle without waiting for pixel_ready.
module line_rasterizer #(
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter int COLOR_W  = 1,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [XW-1:0]      x0,
  input  logic [XW-1:0]      x1,
  input  logic [YW-1:0]      y0,
  input  logic [YW-1:0]      y1,
  input  logic [COLOR_W-1:0] color_in,
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic [COLOR_W-1:0] color,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state_o
);

  localparam int CW = ((XW > YW) ? XW : YW) + 2;
  localparam logic signed [CW-1:0] ONE     = CW'(1);
  localparam logic signed [CW-1:0] NEG_ONE = -CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INIT   = 2'd1,
    S_DRAW   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [XW-1:0]        x_q, x_d, x1_q, x1_d;
  logic [YW-1:0]        y_q, y_d, y1_q, y1_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic signed [CW-1:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [CW-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [CW-1:0] err_q, err_d, err_x;
  logic signed [CW:0]   e2, dx_e, dy_e;
  logic [XW-1:0]        adx;
  logic [YW-1:0]        ady;
  logic                 vis, advance, at_end;

`ifdef LINE_RASTERIZER_CLIP_EN
  localparam logic [XW:0] SCR_W = (XW+1)'(SCREEN_W);
  localparam logic [YW:0] SCR_H = (YW+1)'(SCREEN_H);
  assign vis = ({1'b0, x_q} < SCR_W) && ({1'b0, y_q} < SCR_H);
`else
  // Screen bounds only matter when clipping is compiled in.
  logic scr_unused;
  assign scr_unused = ^{SCREEN_W, SCREEN_H};
  assign vis = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      color_q <= color_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    color_d = color_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    err_d   = err_q;

    // In INIT, x_q/y_q still hold the start point x0/y0.
    adx    = (x1_q >= x_q) ? (x1_q - x_q) : (x_q - x1_q);
    ady    = (y1_q >= y_q) ? (y1_q - y_q) : (y_q - y1_q);
    at_end = (x_q == x1_q) && (y_q == y1_q);
    // Clipped pixels step on without a consumer handshake.
    advance = (state_q == S_DRAW) && (pixel_ready || !vis);

    e2    = {err_q, 1'b0};
    dx_e  = {dx_q[CW-1], dx_q};
    dy_e  = {dy_q[CW-1], dy_q};
    err_x = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          x_d     = x0;
          y_d     = y0;
          x1_d    = x1;
          y1_d    = y1;
          color_d = color_in;
        end
      end
      S_INIT: begin
        dx_d    = $signed(CW'(adx));
        dy_d    = -$signed(CW'(ady));
        sx_d    = (x1_q >= x_q) ? ONE : NEG_ONE;
        sy_d    = (y1_q >= y_q) ? ONE : NEG_ONE;
        err_d   = $signed(CW'(adx)) - $signed(CW'(ady));
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (advance) begin
          if (at_end) begin
            state_d = S_FINISH;
          end else begin
            // Both decisions use the error value from before this step.
            if (e2 >= dy_e) begin
              err_x = err_q + dy_q;
              x_d   = x_q + sx_q[XW-1:0];
            end
            err_d = err_x;
            if (e2 <= dx_e) begin
              err_d = err_x + dx_q;
              y_d   = y_q + sy_q[YW-1:0];
            end
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign x           = x_q;
  assign y           = y_q;
  assign color       = color_q;
  assign pixel_valid = (state_q == S_DRAW) && vis;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign dbg_state_o = state_q;

endmodule
